instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
Fetch/decode stage directly upstream of the multicycle Control FSM. Consumes PC, ReadFlag and instruction from Control, and runs a req/ack handshake with instruction memory. Latches the 16-bit instruction word into IR and supplies the decoded Opcode, register fields, immediate, branchFlag and branchAddress back to Control and the datapath.

Parameters:
IW, 16, instruction word width
AW, 13, PC / instruction address width
TIMEOUT, 15, max WAIT cycles before fetch abort (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
PC  in  13  current instruction address from Control
ReadFlag  in  1  fetch read enable from Control
instruction  in  1  fetch window strobe from Control
alu_zero  in  1  ALU equality result, used for BEQ
imem_req  out  1  memory read request
imem_addr  out  13  memory read address
imem_ack  in  1  memory data valid
imem_rdata  in  16  memory read data
Opcode  out  3  IR[15:13]
rd  out  3  IR[12:10]
rs1  out  3  IR[9:7]
rs2  out  3  IR[6:4]
imm  out  16  sign-extended IR[6:0]
ir_valid  out  1  IR holds the instruction for the current fetch
fetch_busy  out  1  high in REQ/WAIT (and PF_WAIT)
fetch_err  out  1  sticky timeout flag
branchFlag  out  1  take branch
branchAddress  out  13  branch target

Behaviour:
- Reset (async, immediate): state IDLE; IR=0, pc_q=0, ir_valid=0, imem_req=0, imem_addr=0, fetch_err=0, wait counter=0. All outputs derived from IR therefore read 0.
- start = ReadFlag & instruction & ~ir_valid.
- IDLE: on start, latch pc_q<=PC and go to REQ. Otherwise hold.
- REQ: imem_req=1, imem_addr=pc_q.
  - If imem_ack is high the same cycle: IR<=imem_rdata, go to HOLD.
  - Otherwise go to WAIT with counter=0.
- WAIT: imem_req stays 1 and imem_addr stays pc_q.
  - On imem_ack: IR<=imem_rdata, go to HOLD.
  - Otherwise, when counter==TIMEOUT-1: IR<=0 (forced ADD r0,r0,r0), fetch_err<=1, go to HOLD.
  - Otherwise increment counter.
  - If ack and timeout occur in the same cycle, ack wins.
- HOLD: ir_valid=1, and IR and pc_q are frozen. When instruction==0, go to IDLE; ir_valid falls the next cycle.
- Latency: start in cycle N, req in N+1, zero-wait ack in N+1, ir_valid and Opcode valid in N+2.
- imem_req deasserts the cycle after the ack.
- PC changes while not IDLE are ignored; pc_q is used throughout.
- Decode is combinational from IR:
  - imm = {{9{IR[6]}},IR[6:0]}.
- Branch outputs:
  - branchFlag = ir_valid & (Opcode==3'b100 | (Opcode==3'b101 & alu_zero)).
  - branchAddress = IR[12:0] when Opcode==3'b100; otherwise pc_q + sext13(IR[6:0]), modulo 2^13 (wraps, no carry out).
- fetch_err clears only on reset.
- Reset mid-handshake drops imem_req the same instant. Memory must tolerate an abandoned request.

Optional Feature:
Macro INSTR_FETCH_PREFETCH_EN.
- Defined:
  - One-entry prefetch buffer: pf_valid, pf_addr[12:0], pf_data[15:0].
  - In HOLD, if pf_valid==0, issue imem_req for pc_q+1 (wrapping). Its ack fills the buffer.
  - If instruction drops with the prefetch still outstanding, go to PF_WAIT and finish it (same TIMEOUT). A prefetch timeout discards it and does not set fetch_err. Then go to IDLE.
  - On start with pf_valid and pf_addr==PC: IR<=pf_data, pf_valid<=0, skip to HOLD. ir_valid appears at N+1, with no memory request.
  - On start with mismatch: pf_valid<=0 and fetch normally.
- Undefined: no buffer, no PF_WAIT state, no request issued in HOLD. Behaviour is exactly as above.

Test Plan:
- Zero-wait fetch: PC=0x005, rdata=0x2A85 acked in the REQ cycle -> ir_valid at N+2, Opcode=001, rd=2, rs1=5, rs2=0, imm=0x0005, branchFlag=0.
- 3-cycle ack latency: imem_req held with imem_addr=pc_q for 4 cycles, IR loaded on ack, fetch_busy high throughout, ir_valid the cycle after ack.
- No ack, TIMEOUT=15: after 15 WAIT cycles IR=0 and fetch_err=1, and fetch_err stays 1 across later successful fetches until reset.
- Branches:
  - BR 0x8123 -> branchAddress=0x0123, branchFlag=1.
  - BEQ 0xA07F at pc_q=0x0000 -> branchAddress=0x1FFF (wrap); branchFlag follows alu_zero 1/0.
- Async reset asserted in WAIT -> imem_req=0 immediately with no clock edge; all outputs 0; next start refetches cleanly.
- PREFETCH_EN: fetch PC=0x010, drop instruction, then start with PC=0x011 -> IR=mem[0x011] with ir_valid at N+1 and no imem_req. Then start with PC=0x020 -> buffer invalidated and normal fetch.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
//
// Fetch/decode stage that sits in front of the multicycle control FSM.
// Control presents PC with ReadFlag and the instruction window strobe. The
// stage fetches that word from instruction memory over a req/ack handshake,
// holds it in IR, and decodes the opcode, register fields, immediate and
// branch target. A fetch that gets no ack within TIMEOUT wait cycles is
// abandoned. IR is then forced to 0 (ADD r0,r0,r0) and the sticky fetch_err
// flag is set.
//
// Optional feature (compile-time macro INSTR_FETCH_PREFETCH_EN):
//   adds a one-entry prefetch buffer. While in HOLD, the stage reads pc+1
//   into the buffer. A later start whose PC matches the buffer goes straight
//   to HOLD without a memory access. Without the macro, no buffer exists and
//   no request is ever issued in HOLD.
//
// Parameters: IW instruction width (16), AW address width (13),
//             TIMEOUT wait cycles before abort (>=1)
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   PC                    instruction address from control
//   ReadFlag, instruction fetch enable and fetch window strobe
//   alu_zero              ALU equality result used by BEQ
//   imem_req/addr         memory read request and address
//   imem_ack/rdata        memory data valid and read data
//   Opcode, rd, rs1, rs2  decoded IR fields
//   imm                   sign-extended IR[6:0]
//   ir_valid              IR holds the instruction for the current fetch
//   fetch_busy            a memory fetch is in flight
//   fetch_err             sticky fetch timeout flag
//   branchFlag            branch taken
//   branchAddress         branch target
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter int IW      = 16,
  parameter int AW      = 13,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] PC,
  input  logic          ReadFlag,
  input  logic          instruction,
  input  logic          alu_zero,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [2:0]    Opcode,
  output logic [2:0]    rd,
  output logic [2:0]    rs1,
  output logic [2:0]    rs2,
  output logic [IW-1:0] imm,
  output logic          ir_valid,
  output logic          fetch_busy,
  output logic          fetch_err,
  output logic          branchFlag,
  output logic [AW-1:0] branchAddress
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

`ifdef INSTR_FETCH_PREFETCH_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_PF_WAIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t        state_q;
  logic [IW-1:0] ir_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] addr_q;
  logic          req_q;
  logic          ir_valid_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic          pf_valid_q;
  logic [AW-1:0] pf_addr_q;
  logic [IW-1:0] pf_data_q;
  logic          pf_pend_q;    // prefetch request outstanding
  logic          pf_issued_q;  // one prefetch attempt per HOLD visit
`endif

  logic          start;
  logic          cnt_done;
  logic [AW-1:0] br_off;

  assign start    = ReadFlag & instruction & ~ir_valid_q;
  assign cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      req_q       <= 1'b0;
      ir_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      pf_pend_q   <= 1'b0;
      pf_issued_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q <= PC;
`ifdef INSTR_FETCH_PREFETCH_EN
            pf_valid_q <= 1'b0;
            if (pf_valid_q && (pf_addr_q == PC)) begin
              // Buffer hit: no memory access, IR is valid next cycle.
              ir_q       <= pf_data_q;
              ir_valid_q <= 1'b1;
              state_q    <= S_HOLD;
            end else begin
              req_q   <= 1'b1;
              addr_q  <= PC;
              state_q <= S_REQ;
            end
`else
            req_q   <= 1'b1;
            addr_q  <= PC;
            state_q <= S_REQ;
`endif
          end
        end

        S_REQ: begin
          if (imem_ack) begin
            ir_q       <= imem_rdata;
            req_q      <= 1'b0;
            ir_valid_q <= 1'b1;
            state_q    <= S_HOLD;
          end else begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          // An ack takes priority over a timeout in the same cycle.
          if (imem_ack) begin
            ir_q       <= imem_rdata;
            req_q      <= 1'b0;
            ir_valid_q <= 1'b1;
            state_q    <= S_HOLD;
          end else if (cnt_done) begin
            ir_q       <= '0;
            err_q      <= 1'b1;
            req_q      <= 1'b0;
            ir_valid_q <= 1'b1;
            state_q    <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_HOLD: begin
`ifdef INSTR_FETCH_PREFETCH_EN
          if (pf_pend_q) begin
            if (imem_ack) begin
              pf_valid_q <= 1'b1;
              pf_addr_q  <= addr_q;
              pf_data_q  <= imem_rdata;
              req_q      <= 1'b0;
              pf_pend_q  <= 1'b0;
            end else if (cnt_done) begin
              // An abandoned prefetch is dropped silently.
              req_q     <= 1'b0;
              pf_pend_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (instruction && !pf_valid_q && !pf_issued_q) begin
            req_q       <= 1'b1;
            addr_q      <= pc_q + 1'b1;
            cnt_q       <= '0;
            pf_pend_q   <= 1'b1;
            pf_issued_q <= 1'b1;
          end
          if (!instruction) begin
            ir_valid_q  <= 1'b0;
            pf_issued_q <= 1'b0;
            if (pf_pend_q && !imem_ack && !cnt_done) state_q <= S_PF_WAIT;
            else                                     state_q <= S_IDLE;
          end
`else
          if (!instruction) begin
            ir_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
`endif
        end

`ifdef INSTR_FETCH_PREFETCH_EN
        S_PF_WAIT: begin
          if (imem_ack) begin
            pf_valid_q <= 1'b1;
            pf_addr_q  <= addr_q;
            pf_data_q  <= imem_rdata;
            req_q      <= 1'b0;
            pf_pend_q  <= 1'b0;
            state_q    <= S_IDLE;
          end else if (cnt_done) begin
            req_q     <= 1'b0;
            pf_pend_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_err  = err_q;
`ifdef INSTR_FETCH_PREFETCH_EN
  assign fetch_busy = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_PF_WAIT);
`else
  assign fetch_busy = (state_q == S_REQ) || (state_q == S_WAIT);
`endif

  // Combinational decode from IR.
  assign Opcode = ir_q[15:13];
  assign rd     = ir_q[12:10];
  assign rs1    = ir_q[9:7];
  assign rs2    = ir_q[6:4];
  assign imm    = {{(IW-7){ir_q[6]}}, ir_q[6:0]};
  assign br_off = {{(AW-7){ir_q[6]}}, ir_q[6:0]};

  assign branchFlag    = ir_valid_q & ((Opcode == 3'b100) | ((Opcode == 3'b101) & alu_zero));
  // The relative target wraps modulo 2^AW; the carry out is dropped.
  assign branchAddress = (Opcode == 3'b100) ? ir_q[AW-1:0] : (pc_q + br_off);

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] PC = '0;
  logic        ReadFlag = 1'b0;
  logic        instruction = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic [2:0]  Opcode, rd, rs1, rs2;
  logic [15:0] imm;
  logic        ir_valid, fetch_busy, fetch_err, branchFlag;
  logic [12:0] branchAddress;

  instr_fetch_decode #(.IW(16), .AW(13), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .PC(PC), .ReadFlag(ReadFlag),
    .instruction(instruction), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .Opcode(Opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .ir_valid(ir_valid), .fetch_busy(fetch_busy),
    .fetch_err(fetch_err), .branchFlag(branchFlag),
    .branchAddress(branchAddress)
  );

  always #5 clk = ~clk;

  // Memory model: acks when a request has been up for 'lat' cycles.
  logic [15:0] mem [0:8191];
  int lat  = 0;
  int rcnt = 0;

  always @(negedge clk) begin
    if (imem_req) begin
      if (rcnt == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
      end
      rcnt++;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      rcnt       = 0;
    end
  end

  int checks = 0;
  int errors = 0;
  bit model_err = 1'b0;

  typedef struct {
    logic [12:0] pc;
    logic [15:0] data;
    int          lat;
    logic [2:0]  op, rd, rs1, rs2;
    logic [15:0] imm;
    logic        bf1, bf0;
    logic [12:0] baddr;
    logic        err;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one fetch starting just after a negedge and checks timing and decode.
  task automatic run_fetch(input string name, input logic [12:0] pc, input int l,
                           input logic [2:0] e_op, input logic [2:0] e_rd,
                           input logic [2:0] e_rs1, input logic [2:0] e_rs2,
                           input logic [15:0] e_imm, input logic e_bf1, input logic e_bf0,
                           input logic [12:0] e_ba, input logic e_err);
    int k, k_exp;
    bit seen, busy_ok;
    lat   = l;
    k_exp = 2 + ((l < TIMEOUT) ? l : TIMEOUT);
    PC = pc; ReadFlag = 1'b1; instruction = 1'b1;
    seen = 1'b0; busy_ok = 1'b1; k = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (ir_valid) begin
        seen = 1'b1;
        k = i;
      end else if (!(imem_req && imem_addr == pc && fetch_busy)) begin
        busy_ok = 1'b0;
      end
      PC = 13'($urandom);  // PC must be ignored while a fetch is in flight
    end
    chk({name, "_latency"}, k, k_exp);
    chk({name, "_busy_req"}, busy_ok, 1);
    chk({name, "_req_drop"}, {imem_req, fetch_busy}, 0);
    alu_zero = 1'b1; #1;
    chk({name, "_opcode"}, Opcode, e_op);
    chk({name, "_rd"}, rd, e_rd);
    chk({name, "_rs1"}, rs1, e_rs1);
    chk({name, "_rs2"}, rs2, e_rs2);
    chk({name, "_imm"}, imm, e_imm);
    chk({name, "_bflag_z1"}, branchFlag, e_bf1);
    chk({name, "_baddr"}, branchAddress, e_ba);
    chk({name, "_err"}, fetch_err, e_err);
    alu_zero = 1'b0; #1;
    chk({name, "_bflag_z0"}, branchFlag, e_bf0);
    @(negedge clk);
    chk({name, "_hold"}, {ir_valid, Opcode}, {1'b1, e_op});
    instruction = 1'b0; ReadFlag = 1'b0;
    @(negedge clk);
    chk({name, "_valid_fall"}, ir_valid, 0);
    for (int i = 0; i < 40 && fetch_busy; i++) @(negedge clk);
    chk({name, "_drain"}, fetch_busy, 0);
  endtask

  // Reference model: decode fields derived arithmetically from the fetched word.
  task automatic model_fetch(input string name, input logic [12:0] pc, input int l);
    int d, op, off, ba;
    d   = (l <= TIMEOUT) ? int'(mem[pc]) : 0;
    op  = d / 8192;
    off = d % 128;
    if (off >= 64) off -= 128;
    ba  = (op == 4) ? (d % 8192) : ((int'(pc) + off + 8192) % 8192);
    if (l > TIMEOUT) model_err = 1'b1;
    run_fetch(name, pc, l, 3'(op), 3'((d / 1024) % 8), 3'((d / 128) % 8), 3'((d / 16) % 8),
              16'(off), (op == 4 || op == 5), (op == 4), 13'(ba), model_err);
  endtask

  initial begin
    int lats [10] = '{0, 1, 2, 3, 4, 7, 14, 15, 16, 200};
    logic [12:0] prev_pc, rpc;

    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);

    vecs[0] = '{13'h005,  16'h2A85, 0,   3'd1, 3'd2, 3'd5, 3'd0, 16'h0005, 1'b0, 1'b0, 13'h000A, 1'b0};
    vecs[1] = '{13'h100,  16'h1234, 3,   3'd0, 3'd4, 3'd4, 3'd3, 16'h0034, 1'b0, 1'b0, 13'h0134, 1'b0};
    vecs[2] = '{13'h0AB,  16'hFFFF, 255, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 13'h00AB, 1'b1};
    vecs[3] = '{13'h040,  16'h8123, 1,   3'd4, 3'd0, 3'd2, 3'd2, 16'h0023, 1'b1, 1'b1, 13'h0123, 1'b1};
    vecs[4] = '{13'h000,  16'hA07F, 2,   3'd5, 3'd0, 3'd0, 3'd7, 16'hFFFF, 1'b1, 1'b0, 13'h1FFF, 1'b1};
    vecs[5] = '{13'h1FFE, 16'hA003, 0,   3'd5, 3'd0, 3'd0, 3'd0, 16'h0003, 1'b1, 1'b0, 13'h0001, 1'b1};
    for (int i = 0; i < 6; i++) mem[vecs[i].pc] = vecs[i].data;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_decode", {Opcode, rd, rs1, rs2, imm}, 0);
    chk("rst_baddr", branchAddress, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 6; i++)
      run_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].lat, vecs[i].op, vecs[i].rd,
                vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].bf1, vecs[i].bf0,
                vecs[i].baddr, vecs[i].err);
    model_err = 1'b1;

    // Async reset while waiting on memory
    lat = 1000; PC = 13'h055; ReadFlag = 1'b1; instruction = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_wait_req", {imem_req, fetch_busy}, 2'b11);
    alu_zero = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_err", fetch_err, 0);
    chk("arst_busy_valid", {fetch_busy, ir_valid, branchFlag}, 0);
    chk("arst_decode", {Opcode, imm, branchAddress, imem_addr}, 0);
    ReadFlag = 1'b0; instruction = 1'b0; alu_zero = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    model_fetch("refetch", 13'h055, 2);

    // Randomized fetches against the model
    prev_pc = 13'h055;
    for (int n = 0; n < 24; n++) begin
      rpc = 13'($urandom);
      if (rpc == prev_pc + 13'd1) rpc = rpc + 13'd2;
      model_fetch($sformatf("rnd%0d", n), rpc, lats[$urandom_range(0, 9)]);
      prev_pc = rpc;
    end

`ifdef INSTR_FETCH_PREFETCH_EN
    mem[13'h010] = 16'h2A85;
    mem[13'h011] = 16'h8ABC;
    model_fetch("pf_first", 13'h010, 1);
    lat = 1;
    PC = 13'h011; ReadFlag = 1'b1; instruction = 1'b1;
    @(negedge clk);
    chk("pf_hit_valid", ir_valid, 1);
    chk("pf_hit_noreq", imem_req, 0);
    chk("pf_hit_opcode", Opcode, 3'd4);
    chk("pf_hit_baddr", branchAddress, 13'h0ABC);
    instruction = 1'b0; ReadFlag = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40 && fetch_busy; i++) @(negedge clk);
    chk("pf_hit_drain", fetch_busy, 0);
    model_fetch("pf_miss", 13'h020, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
